// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, fed from a small write FIFO so a
// producer can queue several bytes while a frame is on the line.
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 87,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_enable,
    input  logic [7:0] data_to_send,
    output logic       ready,
    output logic       outgoing_bit,
    output logic       is_transmitting,
    output logic       done
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             out_q, out_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_s, pop_s, not_empty_s;

    assign push_s      = write_enable && ready_q;
    assign not_empty_s = (count_q != {(PTR_W + 1){1'b0}});

    // FIFO bookkeeping; ready is precomputed from the next count so it is a flop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end else begin
            count_d = count_q;
        end
        ready_d = (count_d != FIFO_FULL);
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (reset_n && push_s) begin
            mem_q[wr_ptr_q] <= data_to_send;
        end
    end

    // Frame sequencer: the shift register is loaded only on a pop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                tx_d  = 1'b0;
                if (not_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    out_d   = 1'b0;
                    tx_d    = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    idx_d   = 3'd0;
                    out_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (idx_q == 3'd7) begin
                        out_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        out_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    done_d = 1'b1;
                    cnt_d  = {CNT_W{1'b0}};
                    // Chain straight into the next start bit when more data waits
                    if (not_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        out_d   = 1'b0;
                        tx_d    = 1'b1;
                        state_d = S_START;
                    end else begin
                        out_d   = 1'b1;
                        tx_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                out_d   = 1'b1;
                tx_d    = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            out_q    <= 1'b1;
            tx_q     <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign ready           = ready_q;
    assign outgoing_bit    = out_q;
    assign is_transmitting = tx_q;
    assign done            = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected bytes are queued when written and
// popped as frames are decoded from the serial line.
module tb_uart_tx;

    logic       clock;
    logic       reset_n;
    logic       we_8, we_256;
    logic [7:0] data_8, data_256;
    logic       ready_8, line_8, tx_8, done_8;
    logic       ready_256, line_256, tx_256, done_256;
    logic       sel;
    logic       mon_line, mon_tx, mon_done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.CLOCKS_PER_BIT(8), .FIFO_DEPTH(4)) dut_8 (
        .clock(clock), .reset_n(reset_n), .write_enable(we_8),
        .data_to_send(data_8), .ready(ready_8), .outgoing_bit(line_8),
        .is_transmitting(tx_8), .done(done_8)
    );

    uart_tx #(.CLOCKS_PER_BIT(256), .FIFO_DEPTH(4)) dut_256 (
        .clock(clock), .reset_n(reset_n), .write_enable(we_256),
        .data_to_send(data_256), .ready(ready_256), .outgoing_bit(line_256),
        .is_transmitting(tx_256), .done(done_256)
    );

    assign mon_line = sel ? line_256 : line_8;
    assign mon_tx   = sel ? tx_256   : tx_8;
    assign mon_done = sel ? done_256 : done_8;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the line to drop; leaves the caller on the first start-bit sample.
    task automatic wait_start(input int lat, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (mon_line !== 1'b0 && n < budget);
        chk("start_latency", 32'(n), 32'(lat));
    endtask

    // Checks one whole frame sample by sample and decodes it mid-bit.
    task automatic check_frame(input int cpb, input bit last);
        logic [7:0] exp_b, got_b;
        logic [9:0] frame;
        int         bad, dones;
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'(exp_q.size()), 32'(1));
            exp_b = 8'h00;
        end else begin
            exp_b = exp_q.pop_front();
        end
        frame = {1'b1, exp_b, 1'b0};
        got_b = 8'h00;
        bad   = 0;
        dones = 0;
        for (int i = 0; i < 10 * cpb; i++) begin
            if (mon_line !== frame[i / cpb]) bad++;
            if (mon_tx !== 1'b1) bad++;
            if (i > 0 && mon_done !== 1'b0) dones++;
            if ((i % cpb) == (cpb / 2) && (i / cpb) >= 1 && (i / cpb) <= 8)
                got_b[(i / cpb) - 1] = mon_line;
            @(negedge clock);
        end
        chk("rx_byte", 32'(got_b), 32'(exp_b));
        chk("frame_shape_bad_cycles", 32'(bad), 32'(0));
        chk("early_done", 32'(dones), 32'(0));
        chk("done_at_frame_end", 32'(mon_done), 32'(1));
        if (last) begin
            chk("idle_line_after", 32'(mon_line), 32'(1));
            chk("idle_tx_after", 32'(mon_tx), 32'(0));
            @(negedge clock);
            chk("done_one_cycle", 32'(mon_done), 32'(0));
        end
    endtask

    initial begin
        int cnt;
        logic [7:0] bb[3];
        reset_n  = 1'b0;
        we_8     = 1'b0;
        data_8   = 8'h00;
        we_256   = 1'b0;
        data_256 = 8'h00;
        sel      = 1'b0;

        // Reset values
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_line", 32'(line_8), 32'(1));
        chk("rst_ready", 32'(ready_8), 32'(1));
        chk("rst_tx", 32'(tx_8), 32'(0));
        chk("rst_done", 32'(done_8), 32'(0));
        chk("rst_line_256", 32'(line_256), 32'(1));
        cnt = 0;
        repeat (100) begin
            @(negedge clock);
            if (line_8 !== 1'b1 || line_256 !== 1'b1) cnt++;
        end
        chk("idle_100_cycles", 32'(cnt), 32'(0));

        // Single byte
        @(posedge clock);
        #1;
        fork
            begin
                we_8 = 1'b1; data_8 = 8'h55; exp_q.push_back(8'h55);
                @(posedge clock); #1 we_8 = 1'b0;
            end
            begin
                wait_start(3, 50);
                check_frame(8, 1'b1);
            end
        join

        // Back-to-back
        bb[0] = 8'hA3; bb[1] = 8'h00; bb[2] = 8'hFF;
        @(posedge clock);
        #1;
        fork
            begin
                for (int j = 0; j < 3; j++) begin
                    we_8 = 1'b1; data_8 = bb[j]; exp_q.push_back(bb[j]);
                    @(posedge clock); #1;
                end
                we_8 = 1'b0;
            end
            begin
                wait_start(3, 50);
                check_frame(8, 1'b0);
                check_frame(8, 1'b0);
                check_frame(8, 1'b1);
            end
        join

        // Full FIFO: sixth write is dropped
        @(posedge clock);
        #1;
        fork
            begin
                for (int j = 0; j < 6; j++) begin
                    chk("ready_before_write", 32'(ready_8), 32'(j < 5));
                    we_8 = 1'b1; data_8 = 8'(j + 1);
                    if (j < 5) exp_q.push_back(8'(j + 1));
                    @(posedge clock); #1;
                end
                we_8 = 1'b0;
            end
            begin
                wait_start(3, 50);
                for (int k = 0; k < 4; k++) check_frame(8, 1'b0);
                check_frame(8, 1'b1);
            end
        join
        cnt = 0;
        repeat (50) begin
            @(negedge clock);
            if (line_8 !== 1'b1) cnt++;
        end
        chk("no_sixth_frame", 32'(cnt), 32'(0));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        // Reset during data bit 3 with two bytes queued
        @(posedge clock);
        #1;
        for (int j = 0; j < 3; j++) begin
            we_8 = 1'b1; data_8 = 8'hC0 + 8'(j);
            @(posedge clock); #1;
        end
        we_8 = 1'b0;
        wait_start(1, 50);
        repeat (34) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_line", 32'(line_8), 32'(1));
        chk("midrst_tx", 32'(tx_8), 32'(0));
        chk("midrst_done", 32'(done_8), 32'(0));
        chk("midrst_ready", 32'(ready_8), 32'(1));
        @(posedge clock);
        #1 reset_n = 1'b1;
        cnt = 0;
        repeat (300) begin
            @(negedge clock);
            if (line_8 !== 1'b1 || tx_8 !== 1'b0 || done_8 !== 1'b0) cnt++;
        end
        chk("midrst_quiet_after", 32'(cnt), 32'(0));

        // Large divisor
        sel = 1'b1;
        @(posedge clock);
        #1;
        fork
            begin
                we_256 = 1'b1; data_256 = 8'h80; exp_q.push_back(8'h80);
                @(posedge clock); #1 we_256 = 1'b0;
            end
            begin
                wait_start(3, 50);
                check_frame(256, 1'b1);
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises 8-bit bytes as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- Sits on the FPGA side, opposite the existing UART receiver, at the same baud configuration. Drives the serial line toward the host or sensor bridge.
- Contains a small write FIFO, so the producer logic can queue several bytes without waiting for each frame to finish.

Parameters:
- CLOCKS_PER_BIT, 87: clock frequency / baud rate, e.g. 10 MHz / 115200 = 87. Legal range 2..256.
- FIFO_DEPTH, 4: number of queued bytes. Must be a power of 2, 2..16.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clock.
- write_enable  input  1  request to enqueue data_to_send this cycle.
- data_to_send  input  8  byte to enqueue; sampled only when write_enable=1 and ready=1.
- ready  output  1  1 = FIFO not full; a write this cycle is accepted.
- outgoing_bit  output  1  serial TX line; idles high.
- is_transmitting  output  1  1 while a frame (start, data or stop bit) is on the line.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - FSM goes to IDLE; FIFO is emptied (read pointer, write pointer and count cleared).
  - Outputs: outgoing_bit=1, is_transmitting=0, done=0, ready=1.
  - Reset mid-frame aborts the frame. The line goes high on the next cycle and queued bytes are discarded.
- All outputs are registered (ready is derived from the registered count). The bit counter is wide enough to hold CLOCKS_PER_BIT-1. The bit index is 3 bits.
- FIFO:
  - A write is accepted iff write_enable=1 and ready=1.
  - A write while full is ignored: no overwrite, no error flag.
  - A pop happens only inside the FSM, as described below.
  - A simultaneous accepted write and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE:
  - outgoing_bit=1, is_transmitting=0.
  - If the FIFO is non-empty: pop the head into the shift register, set outgoing_bit=0 and is_transmitting=1, clear the bit counter, go to START_BIT.
  - A byte written at edge E0 into an empty FIFO drives the start bit from edge E0+2 onward: one cycle for the FIFO write, one for the pop.
- START_BIT:
  - Hold outgoing_bit=0 for exactly CLOCKS_PER_BIT cycles.
  - On the last cycle, drive data bit 0 and go to DATA_BITS with index 0.
- DATA_BITS:
  - Each bit is held exactly CLOCKS_PER_BIT cycles.
  - After bit 7 completes, drive outgoing_bit=1 and go to STOP_BIT.
- STOP_BIT:
  - Hold outgoing_bit=1 for CLOCKS_PER_BIT cycles.
  - On the last cycle, assert done=1 for the following single cycle.
  - If the FIFO is non-empty at that edge: pop and go directly to START_BIT (outgoing_bit=0), so back-to-back frames have no idle gap. is_transmitting stays 1.
  - Otherwise go to IDLE with is_transmitting=0.
- Frame length is exactly 10*CLOCKS_PER_BIT cycles, measured from the first start-bit cycle to the end of the stop bit.
- Bytes written during a frame never alter the byte in flight; the shift register is loaded only at pop.
- Unreachable state encodings return to IDLE with outgoing_bit=1.

Test Plan:
- Reset values: hold reset_n=0 for 3 cycles, then release. Required: outgoing_bit=1, ready=1, is_transmitting=0, done=0, and outgoing_bit stays 1 for 100 cycles.
- Single byte (CLOCKS_PER_BIT=8): write 0x55 at edge E0. Required:
  - Line is 0 from E0+2 for 8 cycles.
  - Then bits 1,0,1,0,1,0,1,0 at 8 cycles each, then stop = 1 for 8 cycles.
  - done pulses once, exactly 80 cycles after the start bit begins.
  - Loopback into the existing receiver yields 0x55.
- Back-to-back (CLOCKS_PER_BIT=8): write 0xA3, 0x00, 0xFF on consecutive cycles. Required:
  - Three contiguous 80-cycle frames with no idle cycle between stop and start.
  - done pulses at 80, 160 and 240 cycles.
  - Receiver gets 0xA3, 0x00, 0xFF in order.
- Full FIFO (FIFO_DEPTH=4, CLOCKS_PER_BIT=8): write 6 bytes 0x01..0x06 on consecutive cycles. Required:
  - Byte 1 is popped first, so ready drops after the 5th write.
  - 0x06 is dropped.
  - Exactly 5 frames are sent: 0x01..0x05.
- Reset mid-frame: assert reset_n=0 during data bit 3 with 2 bytes queued. Required:
  - outgoing_bit=1 and is_transmitting=0 on the next cycle.
  - No done pulse.
  - No further frames after reset release.
- Large divisor (CLOCKS_PER_BIT=256): send 0x80. Required: each bit is 256 cycles with no counter overflow, and the frame is 2560 cycles.
